jpeg_sys_ctrl: RTL and testbench

System controller for the JPEG pipeline. Latches a `sys_config_t` configuration and sequences the datapath through `IDLE -> INIT -> ACTIVE -> SHUTDOWN`. Runs an init timeout and an activity watchdog, and classifies faults into `error_type_t` with a maskable interrupt. Sits directly above the encoder datapath: it drives the datapath enable, mode and priority, and consumes the datapath's status.

---
 rtl/system_config_pkg.sv | 40 ++++
 rtl/jpeg_sys_watchdog.sv | 32 +++
 rtl/jpeg_sys_ctrl.sv | 151 +++++++++++++++
 tb/tb_jpeg_sys_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/system_config_pkg.sv
// Shared JPEG pipeline system types: controller states, configuration word,
// fault classes and the controller counter width.
package system_config;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INIT     = 3'd1,
        ACTIVE   = 3'd2,
        ERROR    = 3'd3,
        SHUTDOWN = 3'd4
    } system_state_t;

    typedef enum logic [1:0] {
        NO_ERROR      = 2'd0,
        PARITY_ERROR  = 2'd1,
        TIMEOUT_ERROR = 2'd2,
        FATAL_ERROR   = 2'd3
    } error_type_t;

    // "priority" is a reserved word, hence the prio field name.
    typedef struct packed {
        logic       enable;
        logic [3:0] mode;
        logic [7:0] prio;
        logic       interrupt_mask;
    } sys_config_t;

    function automatic int ctrl_cnt_w(input int init_cycles, input int timeout_cycles);
        return $clog2(init_cycles > timeout_cycles ? init_cycles : timeout_cycles);
    endfunction

    localparam int CTRL_CNT_W = ctrl_cnt_w(16, 1024);

    typedef struct packed {
        system_state_t state;
        error_type_t   err_type;
        logic          dp_enable;
    } ctrl_status_t;

endpackage

// File: rtl/jpeg_sys_watchdog.sv
// Loadable, clearable, saturating up-counter with an expiry flag against a
// run-time limit; shared between the INIT timeout and the ACTIVE watchdog.
module jpeg_sys_watchdog #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count >= limit);

endmodule

// File: rtl/jpeg_sys_ctrl.sv
// JPEG pipeline system controller: latches configuration, sequences the
// datapath, runs init timeout / activity watchdog and classifies faults.
//
// state    | meaning
// IDLE     | configurable, waiting for start with enable set
// INIT     | datapath initialising, bounded by INIT_CYCLES
// ACTIVE   | datapath enabled, watchdog fed by dp_beat
// ERROR    | fault latched in err_type; FATAL exits only via stop or reset
// SHUTDOWN | datapath disabled, draining until dp_busy drops
module jpeg_sys_ctrl
    import system_config::*;
#(
    parameter int INIT_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [$bits(sys_config_t)-1:0] cfg,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          init_done,
    input  logic                          dp_beat,
    input  logic                          dp_busy,
    input  logic                          parity_err,
    input  logic                          fatal_err,
    input  logic                          err_clear,
    output logic [2:0]                    state,
    output logic                          dp_enable,
    output logic [3:0]                    dp_mode,
    output logic [7:0]                    dp_priority,
    output logic [1:0]                    err_type,
    output logic                          irq,
    output logic                          shutdown_ack
);

    localparam int CNT_W = ctrl_cnt_w(INIT_CYCLES, TIMEOUT_CYCLES);

    system_state_t state_q, state_d;
    error_type_t   err_q, err_d;
    sys_config_t   cfg_in, cfg_q, cfg_eff;
    logic          dp_enable_d, irq_d, ack_d;
    logic [3:0]    mode_d;
    logic [7:0]    prio_d;
    logic          wd_clr, wd_inc, wd_expired;
    logic [CNT_W-1:0] wd_limit;

    assign cfg_in  = sys_config_t'(cfg);
    // A start in the same cycle as a handshake sees the new word.
    assign cfg_eff = (state_q == IDLE && cfg_valid) ? cfg_in : cfg_q;

    assign wd_limit = (state_q == INIT) ? CNT_W'(INIT_CYCLES - 1) : CNT_W'(TIMEOUT_CYCLES - 1);
    assign wd_inc   = (state_q == INIT) || (state_q == ACTIVE);
    assign wd_clr   = (state_d != state_q) || (state_q == ACTIVE && dp_beat);

    jpeg_sys_watchdog #(.W(CNT_W)) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (wd_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (wd_inc),
        .limit    (wd_limit),
        .expired  (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fatal_err)                   state_d = ERROR;
                else if (start && cfg_eff.enable) state_d = INIT;
            end
            INIT: begin
                if (fatal_err)       state_d = ERROR;
                else if (init_done)  state_d = ACTIVE;
                else if (wd_expired) state_d = ERROR;
            end
            ACTIVE: begin
                if (fatal_err || parity_err || wd_expired) state_d = ERROR;
                else if (stop)                             state_d = SHUTDOWN;
            end
            ERROR: begin
                if (err_q == FATAL_ERROR) begin
                    if (stop) state_d = SHUTDOWN;
                end else if (err_clear) begin
                    state_d = IDLE;
                end
            end
            SHUTDOWN: begin
                if (!dp_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_d       = err_q;
        irq_d       = 1'b0;
        mode_d      = dp_mode;
        prio_d      = dp_priority;
        dp_enable_d = (state_d == ACTIVE);
        ack_d       = (state_q == SHUTDOWN) && (state_d == IDLE);
        if (state_q != ERROR && state_d == ERROR) begin
            irq_d = !cfg_eff.interrupt_mask;
            if (fatal_err)                              err_d = FATAL_ERROR;
            else if (state_q == ACTIVE && parity_err)   err_d = PARITY_ERROR;
            else                                        err_d = TIMEOUT_ERROR;
        end else if (state_q == ERROR && state_d == IDLE) begin
            err_d = NO_ERROR;
        end
        if (state_q == IDLE && state_d == INIT) begin
            mode_d = cfg_eff.mode;
            prio_d = cfg_eff.prio;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q        <= '0;
            err_q        <= NO_ERROR;
            dp_enable    <= 1'b0;
            dp_mode      <= '0;
            dp_priority  <= '0;
            irq          <= 1'b0;
            shutdown_ack <= 1'b0;
        end else begin
            if (state_q == IDLE && cfg_valid) cfg_q <= cfg_in;
            err_q        <= err_d;
            dp_enable    <= dp_enable_d;
            dp_mode      <= mode_d;
            dp_priority  <= prio_d;
            irq          <= irq_d;
            shutdown_ack <= ack_d;
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign state     = state_q;
    assign err_type  = err_q;

endmodule

// File: tb/tb_jpeg_sys_ctrl.sv
// Directed bench for jpeg_sys_ctrl with INIT_CYCLES=16, TIMEOUT_CYCLES=8.
module tb_jpeg_sys_ctrl;
    import system_config::*;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    sys_config_t cfg_s;
    logic [$bits(sys_config_t)-1:0] cfg;
    logic        start, stop, init_done, dp_beat, dp_busy;
    logic        parity_err, fatal_err, err_clear;
    logic [2:0]  state;
    logic        dp_enable;
    logic [3:0]  dp_mode;
    logic [7:0]  dp_priority;
    logic [1:0]  err_type;
    logic        irq;
    logic        shutdown_ack;

    int n_cmp = 0;
    int n_mis = 0;

    assign cfg = cfg_s;

    jpeg_sys_ctrl #(.INIT_CYCLES(16), .TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg          (cfg),
        .start        (start),
        .stop         (stop),
        .init_done    (init_done),
        .dp_beat      (dp_beat),
        .dp_busy      (dp_busy),
        .parity_err   (parity_err),
        .fatal_err    (fatal_err),
        .err_clear    (err_clear),
        .state        (state),
        .dp_enable    (dp_enable),
        .dp_mode      (dp_mode),
        .dp_priority  (dp_priority),
        .err_type     (err_type),
        .irq          (irq),
        .shutdown_ack (shutdown_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_st(input string tag, input logic [2:0] st, input logic en,
                             input logic [1:0] et, input logic iq, input logic ak);
        cmp({tag, ".state"},        8'(state),        8'(st));
        cmp({tag, ".dp_enable"},    8'(dp_enable),    8'(en));
        cmp({tag, ".err_type"},     8'(err_type),     8'(et));
        cmp({tag, ".irq"},          8'(irq),          8'(iq));
        cmp({tag, ".shutdown_ack"}, 8'(shutdown_ack), 8'(ak));
    endtask

    task automatic expect_cfg(input string tag, input logic [3:0] md, input logic [7:0] pr);
        cmp({tag, ".dp_mode"},     8'(dp_mode), 8'(md));
        cmp({tag, ".dp_priority"}, dp_priority, pr);
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_s = '0;
        start = 1'b0; stop = 1'b0; init_done = 1'b0; dp_beat = 1'b0; dp_busy = 1'b0;
        parity_err = 1'b0; fatal_err = 1'b0; err_clear = 1'b0;
        tick(); tick();
        expect_st("reset", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_cfg("reset", 4'd0, 8'h00);
        cmp("reset.cfg_ready", 8'(cfg_ready), 8'd1);
        rst_n = 1'b1;
        tick();

        // init and run: start together with the configuration handshake
        cfg_s = '{enable: 1'b1, mode: 4'd5, prio: 8'h3C, interrupt_mask: 1'b0};
        cfg_valid = 1'b1; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        expect_st("init_entry", 3'd1, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_cfg("init_entry", 4'd5, 8'h3C);
        cmp("init_entry.cfg_ready", 8'(cfg_ready), 8'd0);
        repeat (3) begin
            tick();
            expect_st("init_hold", 3'd1, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        expect_st("active_entry", 3'd2, 1'b1, 2'd0, 1'b0, 1'b0);

        // watchdog without beats trips 8 cycles after ACTIVE entry
        repeat (7) begin
            tick();
            expect_st("wd_run", 3'd2, 1'b1, 2'd0, 1'b0, 1'b0);
        end
        tick();
        expect_st("wd_trip", 3'd3, 1'b0, 2'd2, 1'b1, 1'b0);
        tick();
        expect_st("wd_irq_once", 3'd3, 1'b0, 2'd2, 1'b0, 1'b0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        expect_st("wd_clear", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);

        // beat every 7 cycles never trips
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_st("restart", 3'd1, 1'b0, 2'd0, 1'b0, 1'b0);
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        expect_st("restart_active", 3'd2, 1'b1, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 21; i++) begin
            dp_beat = ((i % 7) == 6);
            tick();
            expect_st("wd_beat", 3'd2, 1'b1, 2'd0, 1'b0, 1'b0);
        end
        dp_beat = 1'b0;

        // drain: busy for 5 cycles holds SHUTDOWN 5 cycles
        dp_busy = 1'b1; stop = 1'b1;
        tick();
        stop = 1'b0;
        expect_st("sd_entry", 3'd4, 1'b0, 2'd0, 1'b0, 1'b0);
        repeat (4) begin
            tick();
            expect_st("sd_hold", 3'd4, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        dp_busy = 1'b0;
        tick();
        expect_st("sd_done", 3'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        expect_st("sd_ack_once", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);

        // start with enable=0 is ignored and leaves dp_mode untouched
        cfg_s = '{enable: 1'b0, mode: 4'd9, prio: 8'h77, interrupt_mask: 1'b0};
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        expect_st("dis_start", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_cfg("dis_start", 4'd5, 8'h3C);

        // same-cycle cfg with enable=1 overrides the latched enable=0
        cfg_s = '{enable: 1'b1, mode: 4'hA, prio: 8'h11, interrupt_mask: 1'b1};
        cfg_valid = 1'b1; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        expect_st("new_cfg_start", 3'd1, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_cfg("new_cfg_start", 4'hA, 8'h11);

        // masked parity error
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        parity_err = 1'b1;
        tick();
        parity_err = 1'b0;
        expect_st("par_err", 3'd3, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        expect_st("par_hold", 3'd3, 1'b0, 2'd1, 1'b0, 1'b0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        expect_st("par_clear", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);

        // init timeout: 16 INIT cycles then ERROR
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) begin
            tick();
            expect_st("init_wait", 3'd1, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        tick();
        expect_st("init_timeout", 3'd3, 1'b0, 2'd2, 1'b0, 1'b0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // init_done in the expiry cycle wins
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        expect_st("init_last", 3'd1, 1'b0, 2'd0, 1'b0, 1'b0);
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        expect_st("init_race", 3'd2, 1'b1, 2'd0, 1'b0, 1'b0);

        // simultaneous fatal/parity/stop -> FATAL, sticky
        parity_err = 1'b1; fatal_err = 1'b1; stop = 1'b1;
        tick();
        parity_err = 1'b0; fatal_err = 1'b0; stop = 1'b0;
        expect_st("fatal", 3'd3, 1'b0, 2'd3, 1'b0, 1'b0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        expect_st("fatal_noclr", 3'd3, 1'b0, 2'd3, 1'b0, 1'b0);
        parity_err = 1'b1;
        tick();
        parity_err = 1'b0;
        expect_st("fatal_keep", 3'd3, 1'b0, 2'd3, 1'b0, 1'b0);
        stop = 1'b1; dp_busy = 1'b1;
        tick();
        stop = 1'b0;
        expect_st("fatal_stop", 3'd4, 1'b0, 2'd3, 1'b0, 1'b0);
        fatal_err = 1'b1;
        tick();
        fatal_err = 1'b0;
        expect_st("sd_ignore", 3'd4, 1'b0, 2'd3, 1'b0, 1'b0);
        dp_busy = 1'b0;
        tick();
        cmp("fatal_sd_done.state", 8'(state), 8'd0);
        cmp("fatal_sd_done.ack", 8'(shutdown_ack), 8'd1);

        // unmasked fatal from IDLE raises irq
        cfg_s = '{enable: 1'b1, mode: 4'd3, prio: 8'h42, interrupt_mask: 1'b0};
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0; fatal_err = 1'b1;
        tick();
        fatal_err = 1'b0;
        expect_st("idle_fatal", 3'd3, 1'b0, 2'd3, 1'b1, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        cmp("idle_fatal_exit", 8'(state), 8'd0);

        // reset during ACTIVE
        start = 1'b1;
        tick();
        start = 1'b0;
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        expect_st("pre_reset", 3'd2, 1'b1, 2'd3, 1'b0, 1'b0);
        expect_cfg("pre_reset", 4'd3, 8'h42);
        rst_n = 1'b0;
        #1;
        expect_st("mid_reset", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_cfg("mid_reset", 4'd0, 8'h00);
        tick();
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_st("post_reset_start", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
